cache_fill_fsm: RTL and testbench

Miss-handling controller that sits directly upstream of the 2 KB 2-way cache and refills a 16 B block from main memory after a miss. It latches the missing address, issues eight sequential word reads to a fixed-latency pipelined memory, and streams returned words into the cache data array. It then writes the tag/valid metadata and releases the pipeline stall. One instance serves each cache (I-cache and D-cache).

---
 rtl/cache_fill_fsm_pkg.sv | 26 ++
 rtl/cache_fill_fsm_if.sv | 43 ++++
 rtl/cache_fill_fsm_fill_counter.sv | 27 ++
 rtl/cache_fill_fsm.sv | 115 +++++++++++
 tb/tb_cache_fill_fsm.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache types and geometry for the
// block refill controller.
package cache_fill_fsm_pkg;

  localparam int BLOCK_OFFSET_W = 4;
  localparam int WORD_OFFSET_W  = 3;
  localparam int TAG_W          = 6;
  localparam int INDEX_W        = 6;
  localparam int WORDS          = 8;
  localparam int MEM_LATENCY    = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    META
  } fill_state_t;

  // byte address of word idx inside the block at base
  function automatic logic [15:0] word_addr(
    input logic [15:0]              base,
    input logic [WORD_OFFSET_W-1:0] idx
  );
    return {base[15:BLOCK_OFFSET_W], idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss, memory and cache-strobe signals of one
// refill controller.
interface cache_fill_fsm_if;
  import cache_fill_fsm_pkg::*;

  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic [15:0] cache_address;
  logic        write_data_array;
  logic        write_tag_array;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data,
    input  memory_data_valid,
    output fsm_busy,
    output memory_read,
    output memory_address,
    output cache_address,
    output write_data_array,
    output write_tag_array
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data,
    output memory_data_valid,
    input  fsm_busy,
    input  memory_read,
    input  memory_address,
    input  cache_address,
    input  write_data_array,
    input  write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Small word counter with clear, enable and a
// flag when it sits on its last value.
module fill_counter #(
  parameter int W    = 3,
  parameter int LAST = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // clear wins over enable; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == W'(LAST));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss refill controller: issues a block
// of word reads, streams data, then writes tag.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cache_fill_fsm_if.master  bus
);

  fill_state_t r_state;
  fill_state_t w_next;
  logic [15:0] r_base;
  logic        r_issue_done;
  logic        w_clr;
  logic        w_issue_en;
  logic        w_recv_en;
  logic        w_issue_last;
  logic        w_recv_last;
  logic [WORD_OFFSET_W-1:0] w_issue_cnt;
  logic [WORD_OFFSET_W-1:0] w_recv_cnt;

  fill_counter #(
    .W    (WORD_OFFSET_W),
    .LAST (WORDS - 1)
  ) u_issue (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_issue_en),
    .o_cnt  (w_issue_cnt),
    .o_last (w_issue_last)
  );

  fill_counter #(
    .W    (WORD_OFFSET_W),
    .LAST (WORDS - 1)
  ) u_recv (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_recv_en),
    .o_cnt  (w_recv_cnt),
    .o_last (w_recv_last)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // block base latched when a miss is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_base <= '0;
    else if (w_clr) r_base <= bus.miss_address & 16'hFFF0;
  end

  // 3-bit issue counter wraps, so remember when
  // the last request has gone out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_issue_done <= 1'b0;
    else if (w_clr)
      r_issue_done <= 1'b0;
    else if (w_issue_en && w_issue_last)
      r_issue_done <= 1'b1;
  end

  // next state, counter controls and strobes
  always_comb begin
    w_next               = r_state;
    w_clr                = 1'b0;
    w_issue_en           = 1'b0;
    w_recv_en            = 1'b0;
    bus.fsm_busy         = 1'b0;
    bus.memory_read      = 1'b0;
    bus.memory_address   = '0;
    bus.cache_address    = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.miss_detected) begin
          w_clr  = 1'b1;
          w_next = FILL;
        end
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        if (!r_issue_done) begin
          w_issue_en         = 1'b1;
          bus.memory_read    = 1'b1;
          bus.memory_address =
            word_addr(r_base, w_issue_cnt);
        end
        if (bus.memory_data_valid) begin
          w_recv_en            = 1'b1;
          bus.write_data_array = 1'b1;
          bus.cache_address    =
            word_addr(r_base, w_recv_cnt);
          if (w_recv_last) w_next = META;
        end
      end
      META: begin
        bus.fsm_busy        = 1'b1;
        bus.write_tag_array = 1'b1;
        bus.cache_address   = r_base;
        w_next              = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a
// fixed-latency pipelined memory model.
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 4;
  int cyc   = 0;
  bit stray = 1'b0;

  int          sched_c [256] = '{default: -1};
  logic [15:0] sched_d [256];

  always @(posedge clk) cyc <= cyc + 1;

  // memory accepts requests mid-cycle
  always @(negedge clk) begin
    if (bus.memory_read === 1'b1) begin
      sched_c[(cyc + lat) % 256] = cyc + lat;
      sched_d[(cyc + lat) % 256] =
        16'h1000 + {13'd0, bus.memory_address[3:1]};
    end
  end

  // memory returns just after the edge
  always @(posedge clk) begin
    #1;
    if (sched_c[cyc % 256] == cyc) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = sched_d[cyc % 256];
    end else begin
      bus.memory_data_valid = stray;
      bus.memory_data       = stray ? 16'hDEAD : 16'h0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(
    input int          k,
    input logic [15:0] base
  );
    logic        e_busy, e_rd, e_wd, e_wt;
    logic [15:0] e_ma, e_ca;
    e_busy = (k <= 9 + lat);
    e_rd   = (k >= 1 && k <= 8);
    e_wd   = (k >= 1 + lat && k <= 8 + lat);
    e_wt   = (k == 9 + lat);
    e_ma   = e_rd ? (base | 16'(2 * (k - 1))) : 16'h0;
    e_ca   = e_wd ? (base | 16'(2 * (k - 1 - lat)))
           : (e_wt ? base : 16'h0);
    chk($sformatf("busy_%h_k%0d", base, k),
        16'(bus.fsm_busy), 16'(e_busy));
    chk($sformatf("rd_%h_k%0d", base, k),
        16'(bus.memory_read), 16'(e_rd));
    chk($sformatf("maddr_%h_k%0d", base, k),
        bus.memory_address, e_ma);
    chk($sformatf("wda_%h_k%0d", base, k),
        16'(bus.write_data_array), 16'(e_wd));
    chk($sformatf("caddr_%h_k%0d", base, k),
        bus.cache_address, e_ca);
    chk($sformatf("wta_%h_k%0d", base, k),
        16'(bus.write_tag_array), 16'(e_wt));
    if (e_wd)
      chk($sformatf("mdata_%h_k%0d", base, k),
          bus.memory_data,
          16'h1000 + 16'(k - 1 - lat));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 16'(bus.fsm_busy), 16'h0);
    chk({tag, "_rd"}, 16'(bus.memory_read), 16'h0);
    chk({tag, "_maddr"}, bus.memory_address, 16'h0);
    chk({tag, "_wda"}, 16'(bus.write_data_array), 16'h0);
    chk({tag, "_caddr"}, bus.cache_address, 16'h0);
    chk({tag, "_wta"}, 16'(bus.write_tag_array), 16'h0);
  endtask

  // caller is at a negedge; miss is sampled at
  // the next edge (cycle 0)
  task automatic do_fill(
    input logic [15:0] a,
    input logic [15:0] base,
    input bit          b2b
  );
    bus.miss_detected = 1'b1;
    bus.miss_address  = a;
    for (int k = 1; k <= 10 + lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (b2b) bus.miss_address  = 16'hFFFE;
        else     bus.miss_detected = 1'b0;
      end
      chk_cycle(k, base);
    end
  endtask

  initial begin
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1A36;

    // reset held with a miss pending
    repeat (3) @(negedge clk);
    chk_quiet("rst_hold");
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    @(negedge clk);
    chk_quiet("rst_rel");

    // stray valid while idle
    stray = 1'b1;
    @(negedge clk);
    chk("stray_vld", 16'(bus.memory_data_valid), 16'h1);
    chk_quiet("stray");
    stray = 1'b0;
    @(negedge clk);
    chk_quiet("stray_after");

    // fill with second miss held throughout
    do_fill(16'h1A36, 16'h1A30, 1'b1);
    do_fill(16'hFFFE, 16'hFFF0, 1'b0);
    @(negedge clk);
    chk_quiet("idle_after_b2b");

    // short memory latency
    lat = 1;
    do_fill(16'h0427, 16'h0420, 1'b0);
    lat = 4;
    @(negedge clk);
    chk_quiet("idle_after_lat1");

    // reset in cycle 7 of a fill
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h2468;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus.miss_detected = 1'b0;
      chk_cycle(k, 16'h2460);
    end
    #1 rst = 1'b0;
    #1 chk_quiet("arst");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_quiet($sformatf("post_arst%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
